// File: rtl/diff_freq_serial_in.sv
// diff_freq_serial_in
//   Receive side of the dual-rate serial link. Deserialises one DATA_BIT-wide
//   frame, LSB first, from a single-wire line at a selectable bit period. The
//   frame is armed by a start strobe shared with the transmitter; there is no
//   start-bit detection. Each bit is resolved by a 3-sample majority vote
//   around mid-bit, which rejects single-cycle glitches.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, asserted HIGH (legacy name kept)
//   i_sel_freq   0 = BIT_CLKS_LOW period, 1 = BIT_CLKS_HIGH; latched on start
//   i_start      one-cycle arm strobe (ignored while receiving)
//   i_stop       abort current reception (wins over a same-cycle completion)
//   i_serial     serial line, asynchronous to clk
//   o_data       last completed word, updated only by a completed frame
//   o_busy       high while receiving
//   o_done_tick  one-cycle pulse on the last cycle of a completed frame
module diff_freq_serial_in #(
  parameter int DATA_BIT      = 8,
  parameter int BIT_CLKS_LOW  = 1000,
  parameter int BIT_CLKS_HIGH = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_sel_freq,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_serial,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_busy,
  output logic                o_done_tick
);

  localparam int PMAX = (BIT_CLKS_LOW > BIT_CLKS_HIGH) ? BIT_CLKS_LOW : BIT_CLKS_HIGH;
  localparam int CW   = $clog2(PMAX);
  localparam int BW   = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

  localparam logic [CW-1:0] P_LO     = CW'(BIT_CLKS_LOW);
  localparam logic [CW-1:0] P_HI     = CW'(BIT_CLKS_HIGH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BIT - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        per_q, per_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BIT-1:0]  shift_q, shift_d;
  logic [DATA_BIT-1:0]  data_d;
  logic                 sync_q1, sync_d;
  logic                 tick;

  logic [CW-1:0]        half;
  logic [1:0]           vote_tot;

  assign half     = per_q >> 1;
  assign vote_tot = vote_q + {1'b0, sync_d};

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q1 <= 1'b0;
      sync_d  <= 1'b0;
    end else begin
      sync_q1 <= i_serial;
      sync_d  <= sync_q1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      per_q     <= '0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      vote_q    <= '0;
      shift_q   <= '0;
      o_data    <= '0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      vote_q    <= vote_d;
      shift_q   <= shift_d;
      o_data    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    vote_d    = vote_q;
    shift_d   = shift_q;
    data_d    = o_data;
    tick      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_d   = RECV;
          per_d     = i_sel_freq ? P_HI : P_LO;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          vote_d    = '0;
          shift_d   = '0;
        end
      end
      RECV: begin
        if (i_stop) begin
          state_d = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
          // Votes at H-1, H, H+1; the first sample restarts the tally.
          if (clk_cnt_q == half - 1'b1)
            vote_d = {1'b0, sync_d};
          else if (clk_cnt_q == half)
            vote_d = vote_tot;
          else if (clk_cnt_q == half + 1'b1)
            shift_d[bit_cnt_q] = vote_tot[1];
          if (clk_cnt_q == per_q - 1'b1) begin
            clk_cnt_d = '0;
            vote_d    = '0;
            if (bit_cnt_q == LAST_BIT) begin
              // shift_d, not shift_q: covers a tiny period where H+1 == P-1.
              data_d  = shift_d;
              tick    = 1'b1;
              state_d = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy      = (state_q == RECV);
  assign o_done_tick = tick;

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Testbench for diff_freq_serial_in. A transmitter model drives the line from
// the frame's start cycle; expected words and completion cycles go into a
// scoreboard queue, popped by an independent monitor on each o_done_tick.
module tb_diff_freq_serial_in;

  localparam int DB = 8;
  localparam int PL = 1000;
  localparam int PH = 500;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_sel_freq = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_serial = 1'b1;
  logic [DB-1:0] o_data;
  logic          o_busy;
  logic          o_done_tick;

  diff_freq_serial_in #(.DATA_BIT(DB), .BIT_CLKS_LOW(PL), .BIT_CLKS_HIGH(PH)) dut (
    .clk(clk), .rst_n(rst_n), .i_sel_freq(i_sel_freq), .i_start(i_start),
    .i_stop(i_stop), .i_serial(i_serial), .o_data(o_data), .o_busy(o_busy),
    .o_done_tick(o_done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DB-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int errs = 0;
  int checks = 0;
  logic [DB-1:0] exp_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick must match the oldest expected frame, both in timing
  // and in the word that appears on o_data the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n && o_done_tick) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          e = sb.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("busy_at_tick", o_busy, 1);
          @(posedge clk); #1;
          check("rx_data", o_data, e.data);
          check("busy_after_tick", o_busy, 0);
        end
      end
    end
  end

  // One frame: start strobe in cycle 0, bit k on the line during cycles
  // 1+k*P .. (k+1)*P. Optional single-cycle glitch per bit placed so the
  // synchronised copy is wrong exactly at mid-bit; optional stop, reset,
  // re-start and speed toggle at frame-relative cycle j (-1 = never).
  task automatic send(input logic [DB-1:0] d, input bit hi, input logic [DB-1:0] gmask,
                      input int stop_at, input int rst_at, input int restart_at,
                      input int toggle_at);
    int p, h, c0;
    bit aborted;
    p = hi ? PH : PL;
    h = p / 2;
    aborted = 0;
    @(negedge clk);
    i_start = 1'b1; i_sel_freq = hi; i_stop = 1'b0;
    c0 = cyc;
    if (stop_at < 0 && rst_at < 0) begin
      sb.push_back('{data: d, cyc: c0 + DB * p});
      exp_last = d;
    end
    for (int j = 0; j < DB * p; j++) begin
      @(negedge clk);
      if (j == 0) check("busy_first_cycle", o_busy, 1);
      if (stop_at >= 0 && j == stop_at + 1) begin
        check("busy_after_stop", o_busy, 0);
        aborted = 1;
        break;
      end
      if (j == rst_at) begin
        rst_n = 1'b1;
        #1;
        check("rst_mid_data", o_data, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_tick", o_done_tick, 0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_last = '0;
        aborted = 1;
        break;
      end
      i_start = (j == restart_at);
      i_stop  = (j == stop_at);
      if (toggle_at >= 0 && j >= toggle_at) i_sel_freq = ~hi;
      i_serial = d[j / p] ^ (gmask[j / p] && (j == (j / p) * p + h - 2));
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
    if (aborted) check("data_held", o_data, exp_last);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", o_data, 0);
    check("reset_busy", o_busy, 0);
    check("reset_tick", o_done_tick, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_busy", o_busy, 0);

    // Loopback sequence, back to back.
    send(8'h55, 1, 8'h00, -1, -1, -1, -1);
    send(8'hAA, 0, 8'h00, -1, -1, -1, -1);
    send(8'h55, 1, 8'h00, -1, -1, -1, -1);
    send(8'hF0, 1, 8'h00, -1, -1, -1, -1);
    // Glitches at mid-bit of bits 0, 3, 7.
    send(8'hC3, 1, 8'h89, -1, -1, -1, -1);
    // Abort during bit 4 at low speed; o_data must keep C3.
    send(8'hFF, 0, 8'h00, 4 * PL + 300, -1, -1, -1);
    send(8'($urandom), 1, 8'h00, -1, -1, -1, -1);

    // Start and stop together: must not arm.
    @(negedge clk);
    i_start = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0;
    check("start_stop_busy", o_busy, 0);
    @(negedge clk);
    check("start_stop_busy2", o_busy, 0);

    // Mid-frame re-start and speed toggle must not disturb the frame.
    send(8'h96, 1, 8'h00, -1, -1, 1500, 1000);
    send(8'h5A, 0, 8'h00, -1, -1, 3000, 2000);

    // Reset during bit 5, then a clean frame.
    send(8'hE7, 1, 8'h00, -1, 5 * PH + 100, -1, -1);
    send(8'h3C, 1, 8'h00, -1, -1, -1, -1);

    // Random words with random glitch placement.
    for (int r = 0; r < 3; r++)
      send(8'($urandom), 1, 8'($urandom), -1, -1, -1, -1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
